// File: rtl/bundler_vec.sv
// bundler_vec
//
// Streaming majority-vote bundler for binary hypervectors. A bundle of n
// hypervectors (1..MAX_HVS, chosen at start) arrives one DIM-bit beat at a
// time. Each bit position keeps its own ones counter. Once all n beats have
// been seen, every bit of the result is the majority of that column. Columns
// that split exactly evenly take their value from tie_hv. The result is
// offered on a valid/ready output port.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      begin a bundle (only looked at while idle)
//   num_hvs    number of hypervectors in the bundle, sampled with start
//   in_valid   in_hv carries a beat
//   in_ready   block will take a beat this cycle (registered)
//   in_hv      input hypervector beat
//   tie_hv     tie-break bits, used in the decide cycle
//   busy       high whenever a bundle is in progress
//   err        one-cycle pulse when start arrives with an illegal num_hvs
//   out_valid  out_hv holds a result (registered)
//   out_ready  consumer takes out_hv
//   out_hv     bundled hypervector (registered, kept after handshake)

module bundler_vec #(
  parameter int DIM     = 1024,
  parameter int MAX_HVS = 17,
  localparam int CW     = $clog2(MAX_HVS + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [CW-1:0]  num_hvs,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [DIM-1:0] in_hv,
  input  logic [DIM-1:0] tie_hv,
  output logic           busy,
  output logic           err,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [DIM-1:0] out_hv
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DECIDE,
    OUTPUT
  } state_t;

  state_t        state;
  state_t        state_next;

  logic [CW-1:0] n_reg;
  logic [CW-1:0] beat_cnt;
  logic [CW-1:0] cnt [DIM];

  logic          start_ok;
  logic          start_bad;
  logic          accept;
  logic          last_beat;
  logic [DIM-1:0] vote;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic plus the handshake/qualification strobes that the
  // datapath shares with it. start is only meaningful in IDLE, and a beat is
  // only consumed in ACCUM while in_ready is up.
  always_comb begin
    state_next = state;
    start_ok   = 1'b0;
    start_bad  = 1'b0;
    accept     = 1'b0;
    last_beat  = 1'b0;

    if (state == IDLE && start) begin
      if (num_hvs == '0 || num_hvs > CW'(MAX_HVS)) begin
        start_bad = 1'b1;
      end else begin
        start_ok = 1'b1;
      end
    end

    accept    = (state == ACCUM) && in_valid && in_ready;
    last_beat = accept && (beat_cnt == n_reg - CW'(1));

    case (state)
      IDLE: begin
        if (start_ok) begin
          state_next = ACCUM;
        end
      end
      ACCUM: begin
        if (last_beat) begin
          state_next = DECIDE;
        end
      end
      DECIDE: begin
        state_next = OUTPUT;
      end
      OUTPUT: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Per-column majority. Doubling the count (append a zero) and widening n
  // by one bit keeps the comparison exact without a divide, and equality
  // identifies an even split.
  always_comb begin
    vote = '0;
    for (int b = 0; b < DIM; b++) begin
      if ({cnt[b], 1'b0} > {1'b0, n_reg}) begin
        vote[b] = 1'b1;
      end else if ({cnt[b], 1'b0} == {1'b0, n_reg}) begin
        vote[b] = tie_hv[b];
      end else begin
        vote[b] = 1'b0;
      end
    end
  end

  // Datapath and registered outputs. Counters are cleared when a legal
  // bundle starts, so a bundle abandoned by reset or an earlier bundle can
  // never leak counts into the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_reg     <= '0;
      beat_cnt  <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_hv    <= '0;
      err       <= 1'b0;
      for (int b = 0; b < DIM; b++) begin
        cnt[b] <= '0;
      end
    end else begin
      err <= start_bad;

      if (start_ok) begin
        n_reg    <= num_hvs;
        beat_cnt <= '0;
        in_ready <= 1'b1;
        for (int b = 0; b < DIM; b++) begin
          cnt[b] <= '0;
        end
      end

      if (accept) begin
        beat_cnt <= beat_cnt + CW'(1);
        for (int b = 0; b < DIM; b++) begin
          cnt[b] <= cnt[b] + CW'(in_hv[b]);
        end
        if (last_beat) begin
          in_ready <= 1'b0;
        end
      end

      if (state == DECIDE) begin
        out_hv    <= vote;
        out_valid <= 1'b1;
      end

      if (state == OUTPUT && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: doc/bundler_vec.md
# bundler_vec

Streaming majority-vote bundler for full binary hypervectors. It accepts a run-time-selected number of DIM-bit hypervectors one beat at a time and keeps a per-bit ones counter for each position. It then emits the bundled hypervector through a valid/ready handshake, resolving even-count ties from a caller-supplied tie hypervector. It replaces the single-bit, fixed-count serial bundler in the encoder path, where spatial/temporal bundling of channel hypervectors feeds the seizure classifier.

## Interface
- DIM, 1024, hypervector width in bits (≥1)
- MAX_HVS, 17, maximum hypervectors per bundle (≥1)
- CW, $clog2(MAX_HVS+1), count width (derived; not overridden)

- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a bundle; sampled only in IDLE
- num_hvs  in  CW  hypervectors in this bundle (n); sampled with start
- in_valid  in  1  in_hv holds a beat
- in_ready  out  1  block accepts a beat (registered)
- in_hv  in  DIM  input hypervector beat
- tie_hv  in  DIM  tie-break bits; sampled in DECIDE
- busy  out  1  high in any state except IDLE
- err  out  1  one-cycle pulse on illegal num_hvs
- out_valid  out  1  out_hv valid (registered)
- out_ready  in  1  consumer accepts out_hv
- out_hv  out  DIM  bundled hypervector (registered)

## Operation
- States: IDLE, ACCUM, DECIDE, OUTPUT.
- IDLE:
  - start with 1 ≤ num_hvs ≤ MAX_HVS: latch n, clear all DIM counters and beat count, set in_ready=1, go to ACCUM.
  - start with num_hvs = 0 or num_hvs > MAX_HVS: err=1 for one cycle; stay in IDLE.
- ACCUM: on each in_valid & in_ready cycle, every counter b += in_hv[b] and beat count +1.
  - When the accepted beat is the n-th: in_ready=0 next cycle, go to DECIDE.
  - in_valid gaps are allowed; counters hold through them.
- DECIDE: one cycle. For each b, compare 2·cnt[b] with n at CW+1 bits:
  - greater: out_hv[b]=1
  - less: out_hv[b]=0
  - equal (only possible for even n): out_hv[b]=tie_hv[b]
  - Then set out_valid=1 and go to OUTPUT.
- OUTPUT: hold out_hv and out_valid stable until out_ready=1. On that cycle, out_valid=0 next cycle and return to IDLE.
- start is ignored outside IDLE.
- in_valid outside ACCUM is ignored; no beat is consumed.
- Counters cannot overflow because cnt ≤ n ≤ MAX_HVS < 2^CW.
- out_hv retains its last value after handshake until the next DECIDE.

## Timing
- Reset (asynchronous, any state):
  - Outputs: in_ready=0, busy=0, err=0, out_valid=0, out_hv=0.
  - Internal: counters=0; state=IDLE.
  - Reset mid-bundle abandons the bundle; no partial output.
- start sampled at edge t:
  - busy=1 and in_ready=1 from t+1.
  - The earliest beat is accepted at t+1.
- Last (n-th) beat accepted at edge k: in_ready=0 at k+1 (DECIDE), out_valid=1 at k+2.
- With no input gaps and out_ready=1: start → out_valid takes n+2 cycles, and the block is back in IDLE one cycle after the output handshake.
- The output handshake occurs when out_valid & out_ready are both high at a rising edge. busy falls the following cycle. A new start is accepted from that IDLE cycle.
- err pulses at t+1 for an illegal start; busy stays 0.

## Test plan
- DIM=8, n=3, beats 0xF0, 0xCC, 0xAA, no gaps → out_hv=0xE8; out_valid 5 cycles after start.
- n=2, beats 0xFF, 0xF0, tie_hv=0x5A → out_hv=0xFA (upper nibble majority, lower nibble from tie_hv).
- n=1, beat 0x3C → out_hv=0x3C; n=MAX_HVS=17 with all beats 0xFF → 0xFF; 9×0x0F plus 8×0xF0 → 0x0F.
- n=3 with in_valid gaps of 2 cycles and out_ready held low 5 cycles → out_hv=0xE8 stable throughout; handshake on the first out_ready cycle; busy falls the next cycle.
- num_hvs=0, then num_hvs=18 → err one-cycle pulse each; busy and in_ready stay 0; in_valid beats are ignored.
- Assert rst after 2 of 3 beats → all outputs 0 immediately. A fresh n=3 run (0x01, 0x01, 0x00) gives out_hv=0x01, with no residual counts.
